// File: rtl/mul_regfile_sequencer.sv
// Signed DATA_WIDTH x DATA_WIDTH shift-add multiply sequenced against a dual-read-port
// register file; steals read/write port cycles from the CPU only while READ and WRITE run.
module mul_regfile_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int PA_ADDR    = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [ADDR_WIDTH-1:0] iSrcA,
  input  logic [ADDR_WIDTH-1:0] iSrcB,
  input  logic [ADDR_WIDTH-1:0] iDest,
  input  logic [ADDR_WIDTH-1:0] iCpuReadAddress0,
  input  logic [ADDR_WIDTH-1:0] iCpuReadAddress1,
  input  logic                  iCpuWriteEnable,
  input  logic [ADDR_WIDTH-1:0] iCpuWriteAddress,
  input  logic [DATA_WIDTH-1:0] iCpuDataIn,
  input  logic [DATA_WIDTH-1:0] iReadData0,
  input  logic [DATA_WIDTH-1:0] iReadData1,
  output logic [ADDR_WIDTH-1:0] oReadAddress0,
  output logic [ADDR_WIDTH-1:0] oReadAddress1,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [DATA_WIDTH-1:0] oDataIn,
  output logic                  oMulEnable,
  output logic [DATA_WIDTH-1:0] oParteAlta,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oCpuStall,
  output logic [2:0]            oDbgState
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [ADDR_WIDTH-1:0] PA_A = ADDR_WIDTH'(PA_ADDR);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_LATCH, S_MUL, S_WRITE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_a_q, src_a_d, src_b_q, src_b_d, dest_q, dest_d;
  logic [PW-1:0]         mcand_q, mcand_d, acc_q, acc_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic                  sign_q, sign_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] abs_a, abs_b;
  logic [PW-1:0]         sum;
  logic                  wr_en;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      src_a_q  <= '0;
      src_b_q  <= '0;
      dest_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      src_a_q  <= src_a_d;
      src_b_q  <= src_b_d;
      dest_q   <= dest_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      sign_q   <= sign_d;
      cnt_q    <= cnt_d;
    end
  end

  // Magnitudes are unsigned, so |-2^(W-1)| = 2^(W-1) fits without overflow.
  assign abs_a = iReadData0[DATA_WIDTH-1] ? (~iReadData0 + DATA_WIDTH'(1)) : iReadData0;
  assign abs_b = iReadData1[DATA_WIDTH-1] ? (~iReadData1 + DATA_WIDTH'(1)) : iReadData1;
  assign sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    src_a_d  = src_a_q;
    src_b_d  = src_b_q;
    dest_d   = dest_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          src_a_d = iSrcA;
          src_b_d = iSrcB;
          dest_d  = iDest;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_LATCH;
      S_LATCH: begin
        mcand_d  = {{DATA_WIDTH{1'b0}}, abs_a};
        mplier_d = abs_b;
        sign_d   = iReadData0[DATA_WIDTH-1] ^ iReadData1[DATA_WIDTH-1];
        acc_d    = '0;
        cnt_d    = CW'(DATA_WIDTH);
        state_d  = S_MUL;
      end
      S_MUL: begin
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          acc_d   = sign_q ? (~sum + PW'(1)) : sum;
          state_d = S_WRITE;
        end else begin
          acc_d = sum;
        end
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Port arbitration: CPU owns both ports except for the READ and WRITE cycles.
  always_comb begin
    oReadAddress0 = iCpuReadAddress0;
    oReadAddress1 = iCpuReadAddress1;
    wr_en         = iCpuWriteEnable;
    oWriteAddress = iCpuWriteAddress;
    oDataIn       = iCpuDataIn;
    oMulEnable    = 1'b0;
    oParteAlta    = '0;
    oDone         = 1'b0;
    oCpuStall     = 1'b0;
    case (state_q)
      S_READ: begin
        oReadAddress0 = src_a_q;
        oReadAddress1 = src_b_q;
        oCpuStall     = 1'b1;
      end
      S_WRITE: begin
        wr_en         = (dest_q != PA_A);
        oWriteAddress = dest_q;
        oDataIn       = acc_q[DATA_WIDTH-1:0];
        oMulEnable    = 1'b1;
        oParteAlta    = acc_q[PW-1:DATA_WIDTH];
        oDone         = 1'b1;
        oCpuStall     = iCpuWriteEnable;
      end
      default: ;
    endcase
  end

  assign oWriteEnable = wr_en & Reset;
  assign oBusy        = (state_q != S_IDLE);
  assign oDbgState    = state_q;

endmodule

// File: tb/tb_mul_regfile_sequencer.sv
// Directed bench for mul_regfile_sequencer: a behavioural register file with registered
// reads, a table of signed multiplies, and hand-written arbitration/reset sequences.
module tb_mul_regfile_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iStart;
  logic [7:0]  iSrcA, iSrcB, iDest;
  logic [7:0]  iCpuReadAddress0, iCpuReadAddress1;
  logic        iCpuWriteEnable;
  logic [7:0]  iCpuWriteAddress;
  logic [15:0] iCpuDataIn;
  logic [15:0] iReadData0, iReadData1;
  logic [7:0]  oReadAddress0, oReadAddress1;
  logic        oWriteEnable;
  logic [7:0]  oWriteAddress;
  logic [15:0] oDataIn;
  logic        oMulEnable;
  logic [15:0] oParteAlta;
  logic        oBusy, oDone, oCpuStall;
  logic [2:0]  oDbgState;

  int errors = 0;
  int checks = 0;
  logic [15:0] mem [256];
  logic watch = 1'b0;
  logic bad_seen = 1'b0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  dest;
    logic [15:0] lo;
    logic [15:0] hi;
    int          mode;
  } vec_t;
  vec_t vecs [10];

  mul_regfile_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .PA_ADDR(8)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart),
    .iSrcA(iSrcA), .iSrcB(iSrcB), .iDest(iDest),
    .iCpuReadAddress0(iCpuReadAddress0), .iCpuReadAddress1(iCpuReadAddress1),
    .iCpuWriteEnable(iCpuWriteEnable), .iCpuWriteAddress(iCpuWriteAddress),
    .iCpuDataIn(iCpuDataIn), .iReadData0(iReadData0), .iReadData1(iReadData1),
    .oReadAddress0(oReadAddress0), .oReadAddress1(oReadAddress1),
    .oWriteEnable(oWriteEnable), .oWriteAddress(oWriteAddress), .oDataIn(oDataIn),
    .oMulEnable(oMulEnable), .oParteAlta(oParteAlta), .oBusy(oBusy), .oDone(oDone),
    .oCpuStall(oCpuStall), .oDbgState(oDbgState)
  );

  // clock / register file model
  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (oWriteEnable) mem[oWriteAddress] <= oDataIn;
    if (oMulEnable) mem[8] <= oParteAlta;
    iReadData0 <= mem[oReadAddress0];
    iReadData1 <= mem[oReadAddress1];
    if (watch && (oMulEnable || oWriteEnable)) bad_seen <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [15:0] data);
    iCpuWriteEnable  = 1'b1;
    iCpuWriteAddress = addr;
    iCpuDataIn       = data;
    @(posedge Clock); #1;
    iCpuWriteEnable  = 1'b0;
  endtask

  // mode 0 plain, 1 mid-MUL start + CPU write, 2 WRITE-cycle collision, 3 operand coherence
  task automatic do_mul(input logic [7:0] dest, input logic [15:0] lo, input logic [15:0] hi,
                        input int mode);
    int busy_cnt, done_cnt, done_at;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    iSrcA = 8'd1; iSrcB = 8'd2; iDest = dest;
    if (mode == 3) begin
      iCpuWriteEnable = 1'b1; iCpuWriteAddress = 8'd2; iCpuDataIn = 16'hFFF9;
    end
    iStart = 1'b1;
    @(posedge Clock); #1;
    iStart = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      if (k > 1) begin @(posedge Clock); #1; end
      if (oBusy) busy_cnt++;
      if (oDone) begin
        done_cnt++;
        done_at = k;
        check("write_en", oWriteEnable, (dest != 8'd8));
        check("write_lo", oDataIn, lo);
        check("parte_alta", oParteAlta, hi);
        check("mul_en", oMulEnable, 1);
        if (dest != 8'd8) check("write_addr", oWriteAddress, dest);
      end
      if (k == 1) begin
        check("read_addr0", oReadAddress0, 8'd1);
        check("read_addr1", oReadAddress1, 8'd2);
        check("read_stall", oCpuStall, 1);
      end
      if (k == 10) check("mul_stall", oCpuStall, 0);
      if (mode == 1) begin
        if (k == 8) iStart = 1'b1;
        if (k == 9) iStart = 1'b0;
        if (k == 10) begin
          iCpuWriteEnable = 1'b1; iCpuWriteAddress = 8'd20; iCpuDataIn = 16'h5555;
          #1;
          check("mul_pass_we", oWriteEnable, 1);
          check("mul_pass_wa", oWriteAddress, 8'd20);
          check("mul_pass_wd", oDataIn, 16'h5555);
          check("mul_pass_ra0", oReadAddress0, 8'hAA);
          check("mul_pass_ra1", oReadAddress1, 8'hBB);
        end
        if (k == 11) begin
          iCpuWriteEnable = 1'b0;
          check("mul_pass_commit", mem[20], 16'h5555);
        end
      end
      if (mode == 2) begin
        if (k == 19) begin
          iCpuWriteEnable = 1'b1; iCpuWriteAddress = 8'd4; iCpuDataIn = 16'h1234;
          #1;
          check("coll_stall", oCpuStall, 1);
          check("coll_addr", oWriteAddress, dest);
        end
        if (k == 20) begin
          check("coll_r4_held", mem[4], 16'h0BAD);
          check("coll_stall_rel", oCpuStall, 0);
          check("coll_fwd_addr", oWriteAddress, 8'd4);
          check("coll_fwd_we", oWriteEnable, 1);
        end
        if (k == 21) begin
          check("coll_r4_commit", mem[4], 16'h1234);
          iCpuWriteEnable = 1'b0;
        end
      end
      if (mode == 3) begin
        if (k == 1) begin
          iCpuWriteAddress = 8'd1; iCpuDataIn = 16'h4000;
          #1;
          check("read_pass_we", oWriteEnable, 1);
          check("read_pass_wa", oWriteAddress, 8'd1);
        end
        if (k == 2) iCpuWriteEnable = 1'b0;
      end
    end
    check("done_count", done_cnt, 1);
    check("done_cycle", done_at, 19);
    check("busy_cycles", busy_cnt, 19);
    if (dest != 8'd8) check("mem_lo", mem[dest], lo);
    check("mem_pa", mem[8], hi);
  endtask

  initial begin
    vecs[0] = '{16'h0003, 16'hFFFE, 8'd3,  16'hFFFA, 16'hFFFF, 0};
    vecs[1] = '{16'h8000, 16'h8000, 8'd5,  16'h0000, 16'h4000, 0};
    vecs[2] = '{16'h7FFF, 16'h8000, 8'd6,  16'h8000, 16'hC000, 1};
    vecs[3] = '{16'h0000, 16'hFFFF, 8'd7,  16'h0000, 16'h0000, 0};
    vecs[4] = '{16'h0005, 16'h0007, 8'd8,  16'h0023, 16'h0000, 0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 8'd3,  16'h0001, 16'h0000, 0};
    vecs[6] = '{16'hFFFD, 16'h0005, 8'd9,  16'hFFF1, 16'hFFFF, 2};
    vecs[7] = '{16'h7FFF, 16'h7FFF, 8'd10, 16'h0001, 16'h3FFF, 0};
    vecs[8] = '{16'h8000, 16'h0001, 8'd11, 16'h8000, 16'hFFFF, 0};
    vecs[9] = '{16'h0100, 16'h0100, 8'd12, 16'h0000, 16'h0001, 0};

    Reset = 1'b0; iStart = 1'b0; iSrcA = '0; iSrcB = '0; iDest = '0;
    iCpuReadAddress0 = 8'hAA; iCpuReadAddress1 = 8'hBB;
    iCpuWriteEnable = 1'b0; iCpuWriteAddress = '0; iCpuDataIn = '0;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_busy", oBusy, 0);
    check("rst_done", oDone, 0);
    check("rst_mul_en", oMulEnable, 0);
    check("rst_pa", oParteAlta, 0);
    check("rst_stall", oCpuStall, 0);
    check("rst_state", oDbgState, 0);
    check("rst_ra0", oReadAddress0, 8'hAA);
    Reset = 1'b1;
    @(posedge Clock); #1;

    cpu_write(8'd4, 16'h0BAD);
    for (int i = 0; i < 10; i++) begin
      cpu_write(8'd1, vecs[i].a);
      cpu_write(8'd2, vecs[i].b);
      do_mul(vecs[i].dest, vecs[i].lo, vecs[i].hi, vecs[i].mode);
    end

    // write committed at E0 is seen, write committed at E1 is not
    cpu_write(8'd1, 16'd6);
    cpu_write(8'd2, 16'd100);
    do_mul(8'd13, 16'hFFD6, 16'hFFFF, 3);

    // reset in the middle of MUL aborts with no write
    cpu_write(8'd1, 16'd2);
    cpu_write(8'd2, 16'd3);
    cpu_write(8'd3, 16'h7777);
    iSrcA = 8'd1; iSrcB = 8'd2; iDest = 8'd3;
    iStart = 1'b1;
    @(posedge Clock); #1;
    iStart = 1'b0;
    for (int k = 2; k <= 10; k++) begin @(posedge Clock); #1; end
    check("pre_abort_busy", oBusy, 1);
    watch = 1'b1;
    Reset = 1'b0;
    iCpuWriteEnable = 1'b1; iCpuWriteAddress = 8'd3; iCpuDataIn = 16'h1111;
    #1;
    check("abort_busy", oBusy, 0);
    check("abort_done", oDone, 0);
    check("abort_mul_en", oMulEnable, 0);
    check("abort_pa", oParteAlta, 0);
    check("abort_stall", oCpuStall, 0);
    check("abort_we_forced", oWriteEnable, 0);
    check("abort_ra0", oReadAddress0, 8'hAA);
    check("abort_ra1", oReadAddress1, 8'hBB);
    repeat (3) @(posedge Clock);
    #1;
    iCpuWriteEnable = 1'b0;
    Reset = 1'b1;
    repeat (15) @(posedge Clock);
    #1;
    watch = 1'b0;
    check("abort_no_write", bad_seen, 0);
    check("abort_dest_kept", mem[3], 16'h7777);
    do_mul(8'd3, 16'h0006, 16'h0000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_regfile_sequencer.md
# mul_regfile_sequencer

- Sequences a signed DATA_WIDTH×DATA_WIDTH multiply against the dual-read-port register file: reads both operands, runs a multi-cycle shift-add multiply, then writes the low half to a destination register and the high half to the PA register.
- Arbitrates the register file's read addresses and single write port between the multiply sequence and normal CPU traffic, stalling the CPU only on the cycles it steals.

## Interface
- DATA_WIDTH, 16, register/operand width
- ADDR_WIDTH, 8, register address width
- PA_ADDR, 8, address of the high-part (PA) register
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- iStart  in  1  multiply request, sampled only in IDLE
- iSrcA, iSrcB  in  ADDR_WIDTH  operand register addresses
- iDest  in  ADDR_WIDTH  destination for low half
- iCpuReadAddress0/1  in  ADDR_WIDTH  CPU read addresses
- iCpuWriteEnable  in  1  CPU writeback request
- iCpuWriteAddress  in  ADDR_WIDTH  CPU writeback address
- iCpuDataIn  in  DATA_WIDTH  CPU writeback data
- iReadData0/1  in  DATA_WIDTH  register file read outputs (registered, 1-cycle latency)
- oReadAddress0/1  out  ADDR_WIDTH  to register file read ports
- oWriteEnable, oWriteAddress, oDataIn  out  1/ADDR_WIDTH/DATA_WIDTH  to register file write port
- oMulEnable  out  1  high-part write strobe
- oParteAlta  out  DATA_WIDTH  high-part data
- oBusy  out  1  state != IDLE
- oDone  out  1  one-cycle pulse in the WRITE cycle
- oCpuStall  out  1  CPU must hold its current read/write

## Operation
- **States:** IDLE → READ → LATCH → MUL → WRITE → IDLE.
- **IDLE**
  - Read and write ports pass the CPU signals straight through.
  - iStart=1 latches iSrcA, iSrcB and iDest, then moves to READ.
- **READ**
  - oReadAddress0/1 = latched SrcA/SrcB.
  - oCpuStall=1.
  - CPU writes still pass through.
- **LATCH**
  - Capture iReadData0/1 as signed operands A, B.
  - Store |A| and |B| as unsigned DATA_WIDTH values; |-2^(W-1)| = 2^(W-1) is exact.
  - Store sign = A[msb]^B[msb].
  - Clear the 2·DATA_WIDTH accumulator and load the iteration counter with DATA_WIDTH.
- **MUL**
  - Radix-2 shift-add, one multiplier bit per cycle, exactly DATA_WIDTH cycles.
  - On the last iteration, negate the product (two's complement, 2·DATA_WIDTH bits) if sign=1, then move to WRITE.
- **WRITE (one cycle)**
  - oWriteEnable=1, oWriteAddress=Dest, oDataIn=product[W-1:0].
  - oMulEnable=1, oParteAlta=product[2W-1:W].
  - oDone=1.
  - If Dest==PA_ADDR, oWriteEnable is forced 0 and only the high half is written.
  - If iCpuWriteEnable=1, the CPU write is not forwarded and oCpuStall=1.
- **Outside READ/WRITE:** oCpuStall=0 and the CPU read addresses pass through.
- **Result:** product is the exact signed 2W-bit result; no saturation.
- iStart while oBusy=1 is ignored.

## Timing
- **Edge sequence**
  - Edge E0 samples iStart in IDLE; READ spans E0–E1.
  - The register file captures operands at E1; LATCH spans E1–E2.
  - Operands are captured at E2.
  - MUL iterates over E3..E(2+W).
  - WRITE spans E(2+W)–E(3+W).
  - The register file commits both halves at E(3+W), i.e. 19 cycles for W=16.
  - Back-to-back multiplies: the next iStart is accepted in the cycle after WRITE.
- **Operand coherence:** a CPU write committed at or before E0 is seen by the multiply; a write committed at E1 or later is not (old value read).
- **Reset** (Reset=0, any time, including mid-operation):
  - state=IDLE, counter=0, accumulator=0.
  - oBusy=0, oDone=0, oMulEnable=0, oParteAlta=0, oCpuStall=0.
  - oWriteEnable forced 0 while Reset=0.
  - oReadAddress0/1 mirror the CPU addresses.
  - An aborted multiply produces no write.

## Test plan
- **Basic signed multiply:** R1=3, R2=-2 (0xFFFE), multiply dest R3 → at E19, R3=0xFFFA and PA=0xFFFF; oDone high exactly one cycle; oBusy high for cycles 1–19.
- **Corner values:**
  - -32768×-32768 → low 0x0000, PA 0x4000.
  - 0x7FFF×0x8000 → low 0x8000, PA 0xC000.
  - 0×-1 → low 0x0000, PA 0x0000.
- **Dest==PA_ADDR:** R1=5, R2=7, iDest=8 → oWriteEnable stays 0 in WRITE; PA=0x0000 (high half wins).
- **Write collision:** CPU holds iCpuWriteEnable=1 (R4←0x1234) during the WRITE cycle → oCpuStall=1 that cycle, R4 unchanged; write commits the cycle after, with oCpuStall=0.
- **Arbitration:**
  - During READ, oReadAddress0/1 = SrcA/SrcB and oCpuStall=1.
  - During MUL, CPU reads and writes pass through untouched.
  - A second iStart pulsed mid-MUL is ignored (exactly one oDone).
- **Reset mid-MUL:** Reset=0 at cycle 10 → all outputs return to reset values immediately; no oMulEnable or oWriteEnable ever asserted; after release, a new multiply completes normally in 19 cycles.
